// File: rtl/sprite_pkg.sv
// Shared types for the sprite animation controller.
//   cfg_addr_e    : register select codes on the config port
//   MODE_*        : bit positions inside the per-channel mode register
//   sprite_chan_t : complete per-channel state (position, motion, animation)
// Field widths are fixed here. The controller's CORDW/ADDRW/CNTW parameters
// must match SPR_CORDW/SPR_ADDRW/SPR_CNTW.
package sprite_pkg;

  localparam int SPR_CORDW = 16;
  localparam int SPR_ADDRW = 12;
  localparam int SPR_CNTW  = 6;
  localparam int SPR_FRW   = 8;

  typedef enum logic [2:0] {
    CFG_X       = 3'd0,
    CFG_Y       = 3'd1,
    CFG_VX      = 3'd2,
    CFG_VY      = 3'd3,
    CFG_PERIOD  = 3'd4,
    CFG_NFRAMES = 3'd5,
    CFG_MODE    = 3'd6,
    CFG_NONE    = 3'd7
  } cfg_addr_e;

  localparam int MODE_EN     = 0;
  localparam int MODE_BOUNCE = 1;
  localparam int MODE_FLIP   = 2;

  typedef struct packed {
    logic signed [SPR_CORDW-1:0] x;
    logic signed [SPR_CORDW-1:0] y;
    logic signed [SPR_CORDW-1:0] vx;
    logic signed [SPR_CORDW-1:0] vy;
    logic [SPR_CNTW-1:0]         period;
    logic [SPR_FRW-1:0]          n_frames;
    logic [2:0]                  mode;
    logic [SPR_CNTW-1:0]         tick;
    logic [SPR_FRW-1:0]          frame_idx;
    logic [SPR_ADDRW-1:0]        base;
    logic                        flip;
  } sprite_chan_t;

  function automatic sprite_chan_t chan_reset(input int h_res);
    sprite_chan_t c;
    c           = '0;
    c.x         = SPR_CORDW'(h_res);
    c.n_frames  = SPR_FRW'(1);
    return c;
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// Combinational single-axis motion step with wrap or bounce edge handling.
//   p, v      : current position / velocity (signed)
//   bounce    : 1 = bounce at [0, BOUNCE_LIM], 0 = wrap between -MARGIN and WRAP_LIM
//   flip_en   : allow a bounce on this axis to request a sprite flip
//   p_nxt     : next position
//   v_nxt     : next velocity (negated on a bounce)
//   flip_tgl  : bounce occurred with flip_en set
module sprite_axis_step #(
  parameter int CORDW      = 16,
  parameter int WRAP_LIM   = 800,
  parameter int MARGIN     = 132,
  parameter int BOUNCE_LIM = 736
) (
  input  logic signed [CORDW-1:0] p,
  input  logic signed [CORDW-1:0] v,
  input  logic                    bounce,
  input  logic                    flip_en,
  output logic signed [CORDW-1:0] p_nxt,
  output logic signed [CORDW-1:0] v_nxt,
  output logic                    flip_tgl
);

  localparam logic signed [CORDW:0] HI   = (CORDW+1)'(WRAP_LIM);
  localparam logic signed [CORDW:0] LO   = -((CORDW+1)'(MARGIN));
  localparam logic signed [CORDW:0] BMAX = (CORDW+1)'(BOUNCE_LIM);

  // One extra bit so p + v cannot overflow before the edge tests.
  logic signed [CORDW:0] n;

  always_comb begin
    n        = (CORDW+1)'(p) + (CORDW+1)'(v);
    p_nxt    = p;
    v_nxt    = v;
    flip_tgl = 1'b0;
    if (v != '0) begin
      if (bounce) begin
        if (n[CORDW]) begin
          p_nxt    = '0;
          v_nxt    = -v;
          flip_tgl = flip_en;
        end else if (n > BMAX) begin
          p_nxt    = BMAX[CORDW-1:0];
          v_nxt    = -v;
          flip_tgl = flip_en;
        end else begin
          p_nxt = n[CORDW-1:0];
        end
      end else begin
        if (v[CORDW-1] && (n < LO)) begin
          p_nxt = HI[CORDW-1:0];
        end else if (!v[CORDW-1] && (n > HI)) begin
          p_nxt = LO[CORDW-1:0];
        end else begin
          p_nxt = n[CORDW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Per-frame motion and animation controller for N_SPR sprite channels.
// On each i_frame pulse the channels are updated one per cycle by a single
// shared datapath (sprite_axis_step for x and y plus the animation counter).
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   i_frame                    : start-of-vblank pulse, triggers an update sweep
//   i_cfg_valid/o_cfg_ready    : config write handshake (accepted only when idle)
//   i_cfg_id/i_cfg_addr/i_cfg_data : channel, register select, write data
//   o_sprx/o_spry              : packed signed positions, channel 0 in LSBs
//   o_base_addr                : ROM base of the current animation frame
//   o_flip/o_en                : horizontal mirror / channel enable
//   o_busy                     : update sweep in progress
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int N_SPR        = 4,
  parameter int CORDW        = SPR_CORDW,
  parameter int ADDRW        = SPR_ADDRW,
  parameter int FRAME_PIXELS = 640,
  parameter int MAX_FRAMES   = 4,
  parameter int CNTW         = SPR_CNTW,
  parameter int H_RES        = 800,
  parameter int V_RES        = 600,
  parameter int SPR_W        = 64,
  parameter int SPR_H        = 40,
  parameter int MARGIN       = 132,
  localparam int IDW         = (N_SPR > 1) ? $clog2(N_SPR) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_frame,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic [IDW-1:0]         i_cfg_id,
  input  logic [2:0]             i_cfg_addr,
  input  logic [CORDW-1:0]       i_cfg_data,
  output logic [N_SPR*CORDW-1:0] o_sprx,
  output logic [N_SPR*CORDW-1:0] o_spry,
  output logic [N_SPR*ADDRW-1:0] o_base_addr,
  output logic [N_SPR-1:0]       o_flip,
  output logic [N_SPR-1:0]       o_en,
  output logic                   o_busy
);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_e;

  state_e                  state;
  logic [IDW-1:0]          idx;
  logic                    pending;
  sprite_chan_t            chan [N_SPR];
  sprite_chan_t            cur;
  sprite_chan_t            nxt;
  logic                    cfg_hit;
  logic                    last_idx;
  logic signed [CORDW-1:0] x_nxt, y_nxt, vx_nxt, vy_nxt;
  logic                    x_tgl, y_tgl;

  assign o_cfg_ready = (state == ST_IDLE) && !pending;
  assign o_busy      = (state == ST_SWEEP);
  assign cfg_hit     = i_cfg_valid && o_cfg_ready && (int'(i_cfg_id) < N_SPR)
                       && (i_cfg_addr != CFG_NONE);
  assign last_idx    = (int'(idx) == N_SPR - 1);
  assign cur         = chan[idx];

  sprite_axis_step #(
    .CORDW      (CORDW),
    .WRAP_LIM   (H_RES),
    .MARGIN     (MARGIN),
    .BOUNCE_LIM (H_RES - SPR_W)
  ) u_step_x (
    .p        (cur.x),
    .v        (cur.vx),
    .bounce   (cur.mode[MODE_BOUNCE]),
    .flip_en  (cur.mode[MODE_FLIP]),
    .p_nxt    (x_nxt),
    .v_nxt    (vx_nxt),
    .flip_tgl (x_tgl)
  );

  // Vertical bounces never mirror the sprite.
  sprite_axis_step #(
    .CORDW      (CORDW),
    .WRAP_LIM   (V_RES),
    .MARGIN     (MARGIN),
    .BOUNCE_LIM (V_RES - SPR_H)
  ) u_step_y (
    .p        (cur.y),
    .v        (cur.vy),
    .bounce   (cur.mode[MODE_BOUNCE]),
    .flip_en  (1'b0),
    .p_nxt    (y_nxt),
    .v_nxt    (vy_nxt),
    .flip_tgl (y_tgl)
  );

  always_comb begin
    nxt = cur;
    if (cur.mode[MODE_EN]) begin
      nxt.x    = x_nxt;
      nxt.vx   = vx_nxt;
      nxt.y    = y_nxt;
      nxt.vy   = vy_nxt;
      nxt.flip = cur.flip ^ (x_tgl | y_tgl);
      if (cur.period != '0) begin
        if (cur.tick == cur.period - CNTW'(1)) begin
          nxt.tick = '0;
          // Base tracks frame_idx*FRAME_PIXELS by accumulation.
          if (cur.frame_idx == cur.n_frames - SPR_FRW'(1)) begin
            nxt.frame_idx = '0;
            nxt.base      = '0;
          end else begin
            nxt.frame_idx = cur.frame_idx + SPR_FRW'(1);
            nxt.base      = cur.base + ADDRW'(FRAME_PIXELS);
          end
        end else begin
          nxt.tick = cur.tick + CNTW'(1);
        end
      end
    end
  end

  function automatic sprite_chan_t cfg_apply(input sprite_chan_t c,
                                             input logic [2:0] a,
                                             input logic [CORDW-1:0] d);
    sprite_chan_t r;
    r = c;
    case (cfg_addr_e'(a))
      CFG_X:      r.x      = d;
      CFG_Y:      r.y      = d;
      CFG_VX:     r.vx     = d;
      CFG_VY:     r.vy     = d;
      CFG_PERIOD: r.period = d[CNTW-1:0];
      CFG_NFRAMES: begin
        if (d == '0)                    r.n_frames = SPR_FRW'(1);
        else if (int'(d) > MAX_FRAMES)  r.n_frames = SPR_FRW'(MAX_FRAMES);
        else                            r.n_frames = d[SPR_FRW-1:0];
        r.frame_idx = '0;
        r.tick      = '0;
        r.base      = '0;
      end
      CFG_MODE: begin
        r.mode = d[2:0];
        if (!d[MODE_FLIP]) r.flip = 1'b0;
      end
      default: ;
    endcase
    return r;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      pending <= 1'b0;
      for (int unsigned k = 0; k < N_SPR; k++) chan[k] <= chan_reset(H_RES);
    end else begin
      case (state)
        ST_IDLE: begin
          if (cfg_hit) chan[i_cfg_id] <= cfg_apply(chan[i_cfg_id], i_cfg_addr, i_cfg_data);
          if (i_frame || pending) begin
            state   <= ST_SWEEP;
            idx     <= '0;
            pending <= 1'b0;
          end
        end
        ST_SWEEP: begin
          chan[idx] <= nxt;
          if (last_idx) begin
            idx <= '0;
            // A queued (or just-arriving) pulse restarts without an idle gap.
            if (pending || i_frame) pending <= 1'b0;
            else                    state   <= ST_IDLE;
          end else begin
            idx <= idx + IDW'(1);
            if (i_frame) pending <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_sprx      = '0;
    o_spry      = '0;
    o_base_addr = '0;
    o_flip      = '0;
    o_en        = '0;
    for (int unsigned k = 0; k < N_SPR; k++) begin
      o_sprx[k*CORDW +: CORDW]      = chan[k].x;
      o_spry[k*CORDW +: CORDW]      = chan[k].y;
      o_base_addr[k*ADDRW +: ADDRW] = chan[k].base;
      o_flip[k]                     = chan[k].flip;
      o_en[k]                       = chan[k].mode[MODE_EN];
    end
  end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl with default parameters
// (4 channels, 16-bit coordinates, 12-bit addresses).
module tb_sprite_anim_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_frame = 1'b0;
  logic        i_cfg_valid = 1'b0;
  logic        o_cfg_ready;
  logic [1:0]  i_cfg_id = '0;
  logic [2:0]  i_cfg_addr = '0;
  logic [15:0] i_cfg_data = '0;
  logic [63:0] o_sprx;
  logic [63:0] o_spry;
  logic [47:0] o_base_addr;
  logic [3:0]  o_flip;
  logic [3:0]  o_en;
  logic        o_busy;

  int checks = 0;
  int failures = 0;

  sprite_anim_ctrl #(
    .N_SPR        (4),
    .FRAME_PIXELS (640),
    .MAX_FRAMES   (4)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_frame     (i_frame),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_id    (i_cfg_id),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_data  (i_cfg_data),
    .o_sprx      (o_sprx),
    .o_spry      (o_spry),
    .o_base_addr (o_base_addr),
    .o_flip      (o_flip),
    .o_en        (o_en),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic int sx(input int k);
    logic [15:0] v;
    v = o_sprx[k*16 +: 16];
    return int'($signed(v));
  endfunction

  function automatic int sy(input int k);
    logic [15:0] v;
    v = o_spry[k*16 +: 16];
    return int'($signed(v));
  endfunction

  function automatic int sb(input int k);
    logic [11:0] v;
    v = o_base_addr[k*12 +: 12];
    return int'(v);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (o_busy && c < 100) begin
      @(posedge i_clk); #1;
      c++;
    end
    if (c >= 100) chk("busy_timeout", c, 0);
  endtask

  task automatic cfg_write(input int id, input int addr, input int data, input bit frm);
    int n;
    n = 0;
    i_cfg_valid = 1'b1;
    i_cfg_id    = 2'(id);
    i_cfg_addr  = 3'(addr);
    i_cfg_data  = 16'(data);
    while (!o_cfg_ready && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (n >= 50) chk("cfg_timeout", n, 0);
    i_frame = frm;
    @(posedge i_clk); #1;
    i_cfg_valid = 1'b0;
    i_frame     = 1'b0;
  endtask

  task automatic frame(output int c);
    i_frame = 1'b1;
    @(posedge i_clk); #1;
    i_frame = 1'b0;
    wait_idle(c);
  endtask

  initial begin
    int c;
    int n;

    // Reset
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    for (int k = 0; k < 4; k++) chk("rst_x", sx(k), 800);
    chk("rst_y0", sy(0), 0);
    chk("rst_base0", sb(0), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ready", int'(o_cfg_ready), 1);
    chk("rst_flip", int'(o_flip), 0);
    chk("rst_en", int'(o_en), 0);

    // Wrap walk on channel 0
    cfg_write(0, 0, -130, 0);
    cfg_write(0, 2, -2, 0);
    cfg_write(0, 6, 1, 0);
    chk("en0", int'(o_en), 1);
    frame(c);
    chk("busy_len", c, 4);
    chk("wrap_x0_a", sx(0), -132);
    chk("disabled_x1", sx(1), 800);
    frame(c);
    chk("wrap_x0_b", sx(0), 800);

    // Bounce with flip on channel 1
    cfg_write(1, 0, 735, 0);
    cfg_write(1, 2, 4, 0);
    cfg_write(1, 6, 7, 0);
    frame(c);
    chk("bnc_x1", sx(1), 736);
    chk("bnc_flip1", int'(o_flip[1]), 1);
    frame(c);
    chk("bnc_x1_back", sx(1), 732);
    chk("bnc_flip1_hold", int'(o_flip[1]), 1);

    // Bounce without flip on channel 2
    cfg_write(2, 0, 735, 0);
    cfg_write(2, 2, 4, 0);
    cfg_write(2, 6, 3, 0);
    frame(c);
    chk("bnc_x2", sx(2), 736);
    chk("bnc_flip2", int'(o_flip[2]), 0);

    // Mode write without flip_on_bounce clears flip
    cfg_write(1, 6, 3, 0);
    chk("flip1_clr", int'(o_flip[1]), 0);

    // Vertical wrap on channel 3
    cfg_write(3, 1, 598, 0);
    cfg_write(3, 3, 3, 0);
    cfg_write(3, 6, 1, 0);
    frame(c);
    chk("wrap_y3", sy(3), -132);
    cfg_write(3, 3, 0, 0);

    // Animation: period 16, 3 frames
    cfg_write(3, 4, 16, 0);
    cfg_write(3, 5, 3, 0);
    for (int p = 1; p <= 48; p++) begin
      frame(c);
      if (p == 15) chk("anim_p15", sb(3), 0);
      if (p == 16) chk("anim_p16", sb(3), 640);
      if (p == 32) chk("anim_p32", sb(3), 1280);
      if (p == 47) chk("anim_p47", sb(3), 1280);
      if (p == 48) chk("anim_p48", sb(3), 0);
    end
    chk("anim_y3_still", sy(3), -132);

    // n_frames=9 clamps to 4: with period 1 the base cycles through 4 frames
    cfg_write(3, 4, 1, 0);
    cfg_write(3, 5, 9, 0);
    for (int p = 1; p <= 4; p++) begin
      frame(c);
      chk("clamp_base", sb(3), (p % 4) * 640);
    end

    // Config write held during a sweep waits for idle
    i_frame = 1'b1;
    @(posedge i_clk); #1;
    i_frame     = 1'b0;
    i_cfg_valid = 1'b1;
    i_cfg_id    = 2'd0;
    i_cfg_addr  = 3'd0;
    i_cfg_data  = 16'd100;
    chk("ready_in_sweep", int'(o_cfg_ready), 0);
    n = 0;
    while (!o_cfg_ready && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("ready_wait", n, 4);
    @(posedge i_clk); #1;
    i_cfg_valid = 1'b0;
    chk("held_write_x0", sx(0), 100);

    // Second pulse mid-sweep queues one sweep; a third is dropped
    i_frame = 1'b1;
    @(posedge i_clk); #1;
    c = 0;
    while (o_busy && c < 100) begin
      i_frame = (c == 1) || (c == 2);
      @(posedge i_clk); #1;
      c++;
    end
    i_frame = 1'b0;
    chk("b2b_busy", c, 8);
    chk("b2b_x0", sx(0), 96);

    // Write and frame in the same idle cycle: the sweep sees the write
    cfg_write(0, 6, 0, 0);
    cfg_write(0, 0, 10, 0);
    cfg_write(0, 2, 5, 0);
    cfg_write(0, 6, 1, 1);
    wait_idle(c);
    chk("same_cycle_x0", sx(0), 15);
    cfg_write(0, 7, 999, 0);
    chk("addr7_x0", sx(0), 15);

    // Asynchronous reset in the middle of a sweep
    i_frame = 1'b1;
    @(posedge i_clk); #1;
    i_frame = 1'b0;
    @(posedge i_clk); #1;
    chk("pre_rst_busy", int'(o_busy), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_x0", sx(0), 800);
    chk("arst_x1", sx(1), 800);
    chk("arst_y3", sy(3), 0);
    chk("arst_base3", sb(3), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_ready", int'(o_cfg_ready), 1);
    chk("arst_en", int'(o_en), 0);
    #2 i_rst_n = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
    chk("post_rst_busy", int'(o_busy), 0);
    chk("post_rst_x0", sx(0), 800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
